// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter, LSB first, valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   input  logic             ser_ready
);

`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CW = $clog2(FRAME_LEN + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [FRAME_LEN-1:0] r_shift;
   logic [FRAME_LEN-1:0] w_shift_nxt;
   logic [FRAME_LEN-1:0] w_frame;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic                 r_out;
   logic                 r_valid;
   logic                 r_last;
   logic                 w_out_nxt;
   logic                 w_valid_nxt;
   logic                 w_last_nxt;
   logic                 w_beat;
   logic                 w_end;
   logic                 w_load;

`ifdef PISO_PARITY_EN
   assign w_frame = {^load_data, load_data};
`else
   assign w_frame = load_data;
`endif

   assign w_beat     = r_valid && ser_ready;
   assign w_end      = w_beat && r_last;
   assign load_ready = (r_state == IDLE) || w_end;
   assign w_load     = load_valid && load_ready;

   assign ser_out   = r_out;
   assign ser_valid = r_valid;
   assign ser_last  = r_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= w_out_nxt;
         r_valid <= w_valid_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // A load on the final beat takes priority so frames run without a bubble.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      w_valid_nxt = r_valid;
      w_last_nxt  = r_last;
      if (w_load) begin
         w_state_nxt = SHIFT;
         w_shift_nxt = w_frame;
         w_cnt_nxt   = '0;
         w_out_nxt   = w_frame[0];
         w_valid_nxt = 1'b1;
         w_last_nxt  = 1'b0;
      end else if (w_end) begin
         w_state_nxt = IDLE;
         w_shift_nxt = '0;
         w_cnt_nxt   = '0;
         w_out_nxt   = 1'b0;
         w_valid_nxt = 1'b0;
         w_last_nxt  = 1'b0;
      end else if (w_beat && r_state == SHIFT) begin
         w_shift_nxt = r_shift >> 1;
         w_cnt_nxt   = r_cnt + CW'(1);
         w_out_nxt   = r_shift[1];
         w_last_nxt  = (r_cnt + CW'(1)) == CW'(FRAME_LEN - 1);
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed frames plus random
// handshakes against a queue-of-pending-bits reference model.
module tb_piso_serializer;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] load_data;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_last;
   logic         ser_ready;

   int errors = 0;
   int checks = 0;
   bit q[$];
   bit got[$];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .ser_last   (ser_last),
      .ser_ready  (ser_ready)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive, compare against the model, then advance the model.
   task automatic step(input logic lv, input logic [W-1:0] ld, input logic sr);
      logic e_valid, e_out, e_last, e_rdy;
      @(negedge clk);
      load_valid = lv;
      load_data  = ld;
      ser_ready  = sr;
      #1;
      e_valid = q.size() > 0;
      e_out   = e_valid ? q[0] : 1'b0;
      e_last  = q.size() == 1;
      e_rdy   = (q.size() == 0) || (q.size() == 1 && sr);
      check("ser_valid", ser_valid, e_valid);
      check("ser_out", ser_out, e_out);
      check("ser_last", ser_last, e_last);
      check("load_ready", load_ready, e_rdy);
      if (ser_valid && sr) got.push_back(ser_out);
      @(posedge clk);
      if (sr && q.size() > 0) void'(q.pop_front());
      if (lv && e_rdy) begin
         for (int i = 0; i < W; i++) q.push_back(ld[i]);
`ifdef PISO_PARITY_EN
         q.push_back(^ld);
`endif
      end
   endtask

   task automatic check_stream(input string tag, input logic [15:0] bits, input int n);
      check({tag, "_len"}, got.size() == n, 1'b1);
      for (int i = 0; i < n; i++)
         check(tag, (i < got.size()) ? got[i] : 1'bx, bits[i]);
      got.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      load_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_valid", ser_valid, 1'b0);
      check("rst_out", ser_out, 1'b0);
      check("rst_last", ser_last, 1'b0);
      check("rst_ready", load_ready, 1'b1);
      q.delete();
      got.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      ser_ready  = 1'b0;
      #1;
      check("init_valid", ser_valid, 1'b0);
      check("init_out", ser_out, 1'b0);
      check("init_last", ser_last, 1'b0);
      check("init_ready", load_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single frame, always ready
      got.delete();
      step(1'b1, 4'b1011, 1'b1);
      repeat (FL) step(1'b0, 4'b0000, 1'b1);
`ifdef PISO_PARITY_EN
      check_stream("frame1011", 16'b11011, FL);
`else
      check_stream("frame1011", 16'b1011, FL);
`endif
      step(1'b0, 4'b0000, 1'b1);

      // Back-to-back frames
      got.delete();
      step(1'b1, 4'b0110, 1'b1);
      repeat (FL) step(1'b1, 4'b1001, 1'b1);
      repeat (FL) step(1'b0, 4'b0000, 1'b1);
`ifdef PISO_PARITY_EN
      check_stream("b2b", 16'b0100100110, 2 * FL);
`else
      check_stream("b2b", 16'b10010110, 2 * FL);
`endif

      // Downstream stall with load attempts while stalled
      got.delete();
      step(1'b1, 4'b1100, 1'b1);
      step(1'b0, 4'b0000, 1'b1);
      repeat (3) step(1'b1, 4'($urandom), 1'b0);
      repeat (FL) step(1'b0, 4'b0000, 1'b1);
      check("stall_b0", got[0], 1'b0);
      check("stall_b1", got[1], 1'b0);
      check("stall_b2", got[2], 1'b1);
      check("stall_b3", got[3], 1'b1);
      got.delete();

      // Reset mid-frame, then a fresh frame
      step(1'b1, 4'b1111, 1'b1);
      step(1'b0, 4'b0000, 1'b1);
      step(1'b0, 4'b0000, 1'b1);
      do_reset();
      step(1'b1, 4'b0001, 1'b1);
      repeat (FL + 1) step(1'b0, 4'b0000, 1'b1);
      check("after_rst_b0", got[0], 1'b1);
      check("after_rst_b1", got[1], 1'b0);
      got.delete();

      // Mid-frame load pulse is ignored
      step(1'b1, 4'b1010, 1'b1);
      step(1'b0, 4'b0000, 1'b1);
      step(1'b1, 4'b0101, 1'b1);
      repeat (FL + 2) step(1'b0, 4'b0000, 1'b1);
      check("ignore_len", got.size() == FL, 1'b1);
      got.delete();

      // Parity-0 word
      step(1'b1, 4'b0011, 1'b1);
      repeat (FL) step(1'b0, 4'b0000, 1'b1);
      check("last_bit_0011", got[FL-1], (FL == W) ? 1'b0 : 1'b0);
      got.delete();

      // Random handshakes
      for (int n = 0; n < 400; n++)
         step(1'($urandom_range(0, 2) != 0), 4'($urandom),
              1'($urandom_range(0, 3) != 0));
      repeat (2 * FL + 2) step(1'b0, 4'($urandom), 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
